// File: rtl/phy_dqs_burst_ctrl_if.sv
// Request/response and DQ/DQS bus bundle for the PHY data/strobe engine.
// A transfer happens on a rising clk edge where valid && ready; rd_valid is a pulse with no ready.
interface phy_dqs_burst_ctrl_if #(
   parameter int DQ_W = 8,
   parameter int BL   = 8
);
   logic                 wr_valid;
   logic                 wr_ready;
   logic [DQ_W*BL-1:0]   wr_data;
   logic                 rd_req_valid;
   logic                 rd_req_ready;
   logic                 rd_valid;
   logic [DQ_W*BL-1:0]   rd_data;
   logic                 rd_err;
   logic [DQ_W-1:0]      dq_o;
   logic                 dq_oe;
   logic [DQ_W-1:0]      dq_i;
   logic                 dqs_p_o;
   logic                 dqs_n_o;
   logic                 dqs_oe;
   logic                 dqs_p_i;

   modport master (
      output wr_valid, wr_data, rd_req_valid, dq_i, dqs_p_i,
      input  wr_ready, rd_req_ready, rd_valid, rd_data, rd_err,
      input  dq_o, dq_oe, dqs_p_o, dqs_n_o, dqs_oe
   );

   modport slave (
      input  wr_valid, wr_data, rd_req_valid, dq_i, dqs_p_i,
      output wr_ready, rd_req_ready, rd_valid, rd_data, rd_err,
      output dq_o, dq_oe, dqs_p_o, dqs_n_o, dqs_oe
   );
endinterface

// File: rtl/phy_dqs_burst_ctrl.sv
// PHY data/strobe engine: serialises write bursts with DQS preamble/toggle/postamble
// and captures read bursts on DQS transitions with a cycle timeout.
module phy_dqs_burst_ctrl #(
   parameter int DQ_W       = 8,
   parameter int BL         = 8,
   parameter int PRE_CYC    = 1,
   parameter int POST_CYC   = 1,
   parameter int RD_TIMEOUT = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   phy_dqs_burst_ctrl_if.slave  bus,
   output logic [2:0]           state_dbg
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR_PRE   = 3'd1,
      WR_BURST = 3'd2,
      WR_POST  = 3'd3,
      RD_BURST = 3'd4
   } state_t;

   localparam int WMAX = (BL > PRE_CYC) ? ((BL > POST_CYC) ? BL : POST_CYC)
                                        : ((PRE_CYC > POST_CYC) ? PRE_CYC : POST_CYC);
   localparam int WCW  = $clog2(WMAX + 1);
   localparam int BW   = $clog2(BL + 1);
   localparam int TW   = $clog2(RD_TIMEOUT + 1);
   localparam int DW   = DQ_W * BL;

   state_t          state_q, state_d;
   logic [WCW-1:0]  wcnt_q, wcnt_d;
   logic [DW-1:0]   wbuf_q, wbuf_d;
   logic [DQ_W-1:0] dq_o_q, dq_o_d;
   logic            dq_oe_q, dq_oe_d;
   logic            dqs_p_o_q, dqs_p_o_d;
   logic            dqs_n_o_q, dqs_n_o_d;
   logic            dqs_oe_q, dqs_oe_d;
   logic [BW-1:0]   beat_q, beat_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic [DW-1:0]   rd_data_q, rd_data_d;
   logic            rd_valid_q, rd_valid_d;
   logic            rd_err_q, rd_err_d;
   logic            dqs_p_q, dqs_p_d;
   logic            p_in;
   logic            rd_edge;

   // X/Z on the returned strobe is treated as a low level.
   assign p_in    = (bus.dqs_p_i === 1'b1);
   assign rd_edge = (p_in != dqs_p_q);

   assign bus.wr_ready     = (state_q == IDLE);
   assign bus.rd_req_ready = (state_q == IDLE) && !bus.wr_valid;
   assign bus.dq_o         = dq_o_q;
   assign bus.dq_oe        = dq_oe_q;
   assign bus.dqs_p_o      = dqs_p_o_q;
   assign bus.dqs_n_o      = dqs_n_o_q;
   assign bus.dqs_oe       = dqs_oe_q;
   assign bus.rd_valid     = rd_valid_q;
   assign bus.rd_data      = rd_data_q;
   assign bus.rd_err       = rd_err_q;
   assign state_dbg        = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wcnt_q     <= '0;
         wbuf_q     <= '0;
         dq_o_q     <= '0;
         dq_oe_q    <= 1'b0;
         dqs_p_o_q  <= 1'b0;
         dqs_n_o_q  <= 1'b1;
         dqs_oe_q   <= 1'b0;
         beat_q     <= '0;
         tcnt_q     <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
         dqs_p_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         wbuf_q     <= wbuf_d;
         dq_o_q     <= dq_o_d;
         dq_oe_q    <= dq_oe_d;
         dqs_p_o_q  <= dqs_p_o_d;
         dqs_n_o_q  <= dqs_n_o_d;
         dqs_oe_q   <= dqs_oe_d;
         beat_q     <= beat_d;
         tcnt_q     <= tcnt_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         rd_err_q   <= rd_err_d;
         dqs_p_q    <= dqs_p_d;
      end
   end

   // Outputs are computed for the cycle after the edge, so bus pins come straight from flops.
   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      wbuf_d     = wbuf_q;
      dq_o_d     = dq_o_q;
      dq_oe_d    = dq_oe_q;
      dqs_p_o_d  = dqs_p_o_q;
      dqs_n_o_d  = dqs_n_o_q;
      dqs_oe_d   = dqs_oe_q;
      beat_d     = beat_q;
      tcnt_d     = tcnt_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      rd_err_d   = rd_err_q;
      dqs_p_d    = p_in;

      case (state_q)
         IDLE: begin
            if (bus.wr_valid) begin
               state_d   = WR_PRE;
               wcnt_d    = '0;
               wbuf_d    = bus.wr_data;
               dqs_oe_d  = 1'b1;
               dqs_p_o_d = 1'b0;
               dqs_n_o_d = 1'b1;
               dq_oe_d   = 1'b0;
            end else if (bus.rd_req_valid) begin
               state_d   = RD_BURST;
               beat_d    = '0;
               tcnt_d    = '0;
               rd_data_d = '0;
               rd_err_d  = 1'b0;
            end
         end

         WR_PRE: begin
            if (wcnt_q == WCW'(PRE_CYC - 1)) begin
               state_d   = WR_BURST;
               wcnt_d    = '0;
               dq_oe_d   = 1'b1;
               dq_o_d    = wbuf_q[DQ_W-1:0];
               wbuf_d    = wbuf_q >> DQ_W;
               dqs_p_o_d = 1'b1;
               dqs_n_o_d = 1'b0;
            end else begin
               wcnt_d = wcnt_q + WCW'(1);
            end
         end

         WR_BURST: begin
            if (wcnt_q == WCW'(BL - 1)) begin
               state_d   = WR_POST;
               wcnt_d    = '0;
               dq_oe_d   = 1'b0;
               dq_o_d    = '0;
               dqs_p_o_d = 1'b0;
               dqs_n_o_d = 1'b1;
            end else begin
               // Next beat index is wcnt_q+1; strobe is high on even beat indices.
               wcnt_d    = wcnt_q + WCW'(1);
               dq_o_d    = wbuf_q[DQ_W-1:0];
               wbuf_d    = wbuf_q >> DQ_W;
               dqs_p_o_d = wcnt_q[0];
               dqs_n_o_d = ~wcnt_q[0];
            end
         end

         WR_POST: begin
            if (wcnt_q == WCW'(POST_CYC - 1)) begin
               state_d   = IDLE;
               wcnt_d    = '0;
               dqs_oe_d  = 1'b0;
               dqs_p_o_d = 1'b0;
               dqs_n_o_d = 1'b1;
            end else begin
               wcnt_d = wcnt_q + WCW'(1);
            end
         end

         RD_BURST: begin
            tcnt_d = tcnt_q + TW'(1);
            if (rd_edge) begin
               for (int i = 0; i < BL; i++) begin
                  if (beat_q == BW'(i)) rd_data_d[i*DQ_W +: DQ_W] = bus.dq_i;
               end
               beat_d = beat_q + BW'(1);
            end
            if (rd_edge && (beat_q == BW'(BL - 1))) begin
               state_d    = IDLE;
               rd_valid_d = 1'b1;
               rd_err_d   = 1'b0;
            end else if (tcnt_q == TW'(RD_TIMEOUT - 1)) begin
               state_d    = IDLE;
               rd_valid_d = 1'b1;
               rd_err_d   = 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_phy_dqs_burst_ctrl.sv
// Bench for phy_dqs_burst_ctrl: drivers push expected strobe frames and read results
// into queues; a negedge monitor pops and compares whatever the DUT presents.
module tb_phy_dqs_burst_ctrl;

   localparam int DQ_W = 8;
   localparam int BL   = 8;
   localparam int PRE  = 1;
   localparam int POST = 1;
   localparam int TO   = 32;
   localparam int DW   = DQ_W * BL;

   // Frame entry: {start_cyc[32], first, last, dq_oe, dq, p, n}
   localparam int F_P     = 1;
   localparam int F_OE    = 2 + DQ_W;
   localparam int F_LAST  = 3 + DQ_W;
   localparam int F_FIRST = 4 + DQ_W;
   localparam int F_START = 5 + DQ_W;
   localparam int FW      = F_START + 32;
   // Read entry: {due_cyc[32], err, data}
   localparam int RW      = 32 + 1 + DW;

   logic clk;
   logic rst_n;
   logic [2:0] state_dbg;
   int   cyc;
   int   tests;
   int   fails;
   logic in_frame;
   logic dqs_lvl;

   logic [FW-1:0] exp_frame_q[$];
   logic [RW-1:0] exp_rd_q[$];

   int            sched_n;
   int            sched_t[BL];
   logic [DQ_W-1:0] sched_v[BL];

   phy_dqs_burst_ctrl_if #(.DQ_W(DQ_W), .BL(BL)) bus ();

   phy_dqs_burst_ctrl #(
      .DQ_W(DQ_W), .BL(BL), .PRE_CYC(PRE), .POST_CYC(POST), .RD_TIMEOUT(TO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flush_model();
      exp_frame_q.delete();
      exp_rd_q.delete();
      in_frame = 1'b0;
   endtask

   // ---------------- reference model / drivers ----------------
   task automatic push_write(input logic [DW-1:0] data, input int start);
      for (int i = 0; i < PRE; i++)
         exp_frame_q.push_back({32'(start), (i == 0), 1'b0, 1'b0, {DQ_W{1'b0}}, 1'b0, 1'b1});
      for (int i = 0; i < BL; i++)
         exp_frame_q.push_back({32'(start), 1'b0, 1'b0, 1'b1, data[i*DQ_W +: DQ_W],
                                (i % 2 == 0), (i % 2 != 0)});
      for (int i = 0; i < POST; i++)
         exp_frame_q.push_back({32'(start), 1'b0, (i == POST - 1), 1'b0, {DQ_W{1'b0}}, 1'b0, 1'b1});
   endtask

   task automatic do_write(input logic [DW-1:0] data, output int acc);
      logic got;
      got = 1'b0;
      acc = -1;
      bus.wr_data  = data;
      bus.wr_valid = 1'b1;
      for (int n = 0; n < 200 && !got; n++) begin
         @(negedge clk);
         got = bus.wr_ready;
         @(posedge clk);
         #1;
      end
      if (!got) begin
         tests++; fails++;
         $display("FAIL wr_accept_timeout: wr_ready never seen, required within 200 cycles");
      end else begin
         acc = cyc;
         push_write(data, cyc);
      end
      bus.wr_valid = 1'b0;
   endtask

   task automatic gen_sched(input int n, input int maxgap);
      int t;
      t = -1;
      sched_n = n;
      for (int j = 0; j < n; j++) begin
         t = t + 1 + int'($urandom_range(0, maxgap));
         sched_t[j] = t;
         sched_v[j] = DQ_W'($urandom);
      end
   endtask

   task automatic do_read(output int acc);
      logic got;
      logic [DW-1:0] data;
      int cnt, last_t, tmax, j;
      got = 1'b0;
      acc = -1;
      bus.rd_req_valid = 1'b1;
      for (int n = 0; n < 200 && !got; n++) begin
         @(negedge clk);
         got = bus.rd_req_ready;
         @(posedge clk);
         #1;
      end
      bus.rd_req_valid = 1'b0;
      if (!got) begin
         tests++; fails++;
         $display("FAIL rd_accept_timeout: rd_req_ready never seen, required within 200 cycles");
         return;
      end
      acc = cyc;
      // Beats count only if their transition falls within the timeout window.
      data = '0;
      cnt = 0;
      last_t = 0;
      for (int k = 0; k < sched_n; k++) begin
         if (sched_t[k] < TO && cnt < BL) begin
            data[cnt*DQ_W +: DQ_W] = sched_v[k];
            cnt++;
            last_t = sched_t[k];
         end
      end
      if (cnt == BL) exp_rd_q.push_back({32'(acc + 1 + last_t), 1'b0, data});
      else           exp_rd_q.push_back({32'(acc + TO), 1'b1, data});
      tmax = (sched_n > 0) ? sched_t[sched_n-1] : 0;
      j = 0;
      for (int t = 0; t <= tmax; t++) begin
         if (j < sched_n && sched_t[j] == t) begin
            dqs_lvl = ~dqs_lvl;
            bus.dqs_p_i = dqs_lvl;
            bus.dq_i = sched_v[j];
            j++;
         end else begin
            bus.dq_i = DQ_W'($urandom);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 300 && (exp_frame_q.size() != 0 || exp_rd_q.size() != 0 || in_frame); i++)
         @(posedge clk);
      #1;
      if (exp_frame_q.size() != 0 || exp_rd_q.size() != 0) begin
         tests++; fails++;
         $display("FAIL drain_timeout: %0d frames and %0d reads outstanding, required 0",
                  exp_frame_q.size(), exp_rd_q.size());
         flush_model();
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin : monitor
      logic [FW-1:0]   f;
      logic [RW-1:0]   r;
      logic [F_OE:0]   act;
      if (rst_n) begin
         if (bus.dqs_oe) begin
            if (exp_frame_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL strobe_unexpected: dqs_oe=1 at cycle %0d, required 0", cyc);
            end else begin
               f = exp_frame_q.pop_front();
               if (f[F_FIRST]) check("wr_start_cycle", 64'(cyc), 64'(f[FW-1 -: 32]));
               act = {bus.dq_oe, (bus.dq_oe ? bus.dq_o : {DQ_W{1'b0}}), bus.dqs_p_o, bus.dqs_n_o};
               check("wr_frame", 64'(act), 64'(f[F_OE:0]));
               in_frame = !f[F_LAST];
            end
         end else begin
            if (in_frame) begin
               tests++; fails++;
               $display("FAIL frame_gap: dqs_oe dropped mid-burst at cycle %0d", cyc);
            end
            in_frame = 1'b0;
            check("dq_oe_idle", 64'(bus.dq_oe), 64'(0));
         end
         if (bus.rd_valid) begin
            if (exp_rd_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL rd_unexpected: rd_valid=1 at cycle %0d, required 0", cyc);
            end else begin
               r = exp_rd_q.pop_front();
               check("rd_data", bus.rd_data, r[DW-1:0]);
               check("rd_err", 64'(bus.rd_err), 64'(r[DW]));
               check("rd_cycle", 64'(cyc), 64'(r[RW-1 -: 32]));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin : stim
      int acc_w, acc_r, n;
      tests = 0;
      fails = 0;
      in_frame = 1'b0;
      dqs_lvl = 1'b0;
      sched_n = 0;
      rst_n = 1'b0;
      bus.wr_valid = 1'b0;
      bus.wr_data = '0;
      bus.rd_req_valid = 1'b0;
      bus.dq_i = '0;
      bus.dqs_p_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_dq_oe", 64'(bus.dq_oe), 64'(0));
      check("rst_dqs_oe", 64'(bus.dqs_oe), 64'(0));
      check("rst_dqs_p", 64'(bus.dqs_p_o), 64'(0));
      check("rst_dqs_n", 64'(bus.dqs_n_o), 64'(1));
      check("rst_dq_o", 64'(bus.dq_o), 64'(0));
      check("rst_rd_valid", 64'(bus.rd_valid), 64'(0));
      check("rst_rd_data", bus.rd_data, 64'(0));
      check("rst_wr_ready", 64'(bus.wr_ready), 64'(1));
      check("rst_rd_req_ready", 64'(bus.rd_req_ready), 64'(1));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // directed write with busy-window length
      do_write(64'h8877665544332211, acc_w);
      n = 0;
      while (!bus.wr_ready && n < 50) begin
         n++;
         @(posedge clk);
         #1;
      end
      check("wr_ready_low_cycles", 64'(n), 64'(PRE + BL + POST));
      wait_drain();

      // full read, strobe toggling every cycle
      sched_n = BL;
      for (int j = 0; j < BL; j++) begin
         sched_t[j] = j;
         sched_v[j] = DQ_W'(8'hA0 + j);
      end
      do_read(acc_r);
      wait_drain();

      // read with only three transitions -> timeout with partial data
      sched_n = 3;
      for (int j = 0; j < 3; j++) begin
         sched_t[j] = j;
         sched_v[j] = DQ_W'(8'hA0 + j);
      end
      do_read(acc_r);
      wait_drain();

      // simultaneous requests: write first, read on first idle cycle after postamble
      gen_sched(BL, 0);
      fork
         do_write({$urandom, $urandom}, acc_w);
         do_read(acc_r);
         begin
            @(negedge clk);
            check("rd_req_ready_blocked", 64'(bus.rd_req_ready), 64'(0));
         end
      join
      check("rd_after_wr_accept", 64'(acc_r), 64'(acc_w + PRE + BL + POST + 1));
      wait_drain();

      // back-to-back writes with wr_valid held
      for (int i = 0; i < 3; i++) do_write({$urandom, $urandom}, acc_w);
      wait_drain();

      // reset during beat 4 of a write
      do_write({$urandom, $urandom}, acc_w);
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      flush_model();
      #1;
      check("rst_wr_dq_oe", 64'(bus.dq_oe), 64'(0));
      check("rst_wr_dqs_oe", 64'(bus.dqs_oe), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // reset during a read
      gen_sched(BL, 1);
      fork
         do_read(acc_r);
         begin
            repeat (4) @(posedge clk);
            #3;
            rst_n = 1'b0;
            flush_model();
            #1;
            check("rst_rd_valid_mid", 64'(bus.rd_valid), 64'(0));
            check("rst_rd_dqs_oe", 64'(bus.dqs_oe), 64'(0));
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
         end
      join
      repeat (TO + 8) @(posedge clk);
      #1;

      // clean write after reset
      do_write(64'h8877665544332211, acc_w);
      wait_drain();

      // randomized mix
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            do_write({$urandom, $urandom}, acc_w);
         end else begin
            gen_sched(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BL - 1)) : BL,
                      int'($urandom_range(0, 4)));
            do_read(acc_r);
         end
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(0, 3)) @(posedge clk);
         #0;
      end
      wait_drain();
      repeat (4) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
